hardware_utf16: RTL and testbench
=================================

Name: hardware_utf16

Overview:
- Neighbouring stage to the UTF-8 codec, attached to its character side.
- Encode path: takes 32-bit code points from the codec and emits UTF-16 code units, splitting non-BMP characters into surrogate pairs.
- Decode path: takes UTF-16 code units, pairs surrogates, and emits 32-bit code points back to the codec.
- Both paths are independent, use valid/ready handshakes and share one clock.

Parameters:
- REPL_CHAR, 16'hFFFD, code unit/point substituted for errors when UTF16_REPLACE_EN is defined.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_in  in  1  reset, synchronous, active-low; clears all state and outputs.
- e_cp  in  32  encode: input code point.
- e_valid  in  1  encode: e_cp valid.
- e_ready  out  1  encode: e_cp accepted this cycle when e_valid & e_ready.
- e_unit  out  16  encode: output code unit.
- e_uvalid  out  1  encode: e_unit valid.
- e_uready  in  1  encode: consumer takes e_unit.
- e_err  out  1  encode: e_unit came from an erroneous code point (>0x10FFFF or lone surrogate).
- d_unit  in  16  decode: input code unit.
- d_valid  in  1  decode: d_unit valid.
- d_ready  out  1  decode: d_unit accepted.
- d_flush  in  1  decode: end of stream; emit any pending high surrogate.
- d_cp  out  32  decode: output code point.
- d_cvalid  out  1  decode: d_cp valid.
- d_cready  in  1  decode: consumer takes d_cp.
- d_err  out  1  decode: d_cp is a lone surrogate.
- d_pend  out  1  decode: high surrogate held.

Behaviour:
- Reset (rst_in=0 at posedge): e_unit=0, e_uvalid=0, e_err=0, d_cp=0, d_cvalid=0, d_err=0, d_pend=0; both FSMs go to IDLE. Reset overrides everything, including a pending low surrogate or held high.
- Output registers: each output register loads when empty or consumed the same cycle (outreg free = !valid | ready). Latency is 1 cycle from accept to valid. Output stays stable while valid & !ready.
- Encode FSM, states E_IDLE and E_LOW:
  - e_ready = E_IDLE & outreg free.
  - On accept of cp < 0x10000: emit cp[15:0], stay in E_IDLE. e_err=1 if 0xD800 <= cp <= 0xDFFF.
  - On accept of 0x10000 <= cp <= 0x10FFFF: let v = cp - 0x10000 (20 bits). Emit 0xD800 | v[19:10]. Latch 0xDC00 | v[9:0]. Go to E_LOW.
  - In E_LOW: when outreg is free, emit the latched low unit and return to E_IDLE. e_ready=0 throughout E_LOW.
  - On accept of cp > 0x10FFFF: emit cp[15:0] with e_err=1 (see optional feature for replacement).
- Decode FSM, states D_IDLE and D_HI (d_pend = D_HI):
  - D_IDLE, unit not a surrogate: emit it zero-extended.
  - D_IDLE, high unit (0xD800–0xDBFF): latch it, go to D_HI, no output.
  - D_IDLE, low unit (0xDC00–0xDFFF): emit it with d_err=1.
  - D_HI, low unit: emit 0x10000 + ((hi & 0x3FF) << 10) + (lo & 0x3FF), d_err=0, go to D_IDLE.
  - D_HI, non-low unit: do NOT accept (d_ready=0). Emit the held high with d_err=1 and go to D_IDLE. The unit is re-evaluated next cycle.
  - D_HI with d_flush=1 and no d_valid: emit the held high with d_err=1 and go to D_IDLE.
  - d_flush in D_IDLE: no effect.
  - d_valid and d_flush together in D_HI: d_valid takes priority.
- d_ready = outreg free, except d_ready=0 in D_HI when d_unit is not a low surrogate.
- Paths never stall each other.

Optional Feature:
- UTF16_REPLACE_EN defined: every unit/code point flagged e_err/d_err carries REPL_CHAR instead (encode e_unit=REPL_CHAR; decode d_cp={16'h0,REPL_CHAR}). The err flag is still asserted.
- Undefined: raw values pass through as specified above.

Decomposition:
- Package hardware_utf16_pkg holds:
  - constants SUR_HI_LO=16'hD800, SUR_LO_LO=16'hDC00, SUR_END=16'hDFFF, MAX_CP=32'h10FFFF, SUPP_BASE=32'h10000;
  - enum typedefs for the encode and decode FSM states;
  - functions is_hi(u) and is_lo(u).
- One natural sub-module, hardware_utf16_outreg: a parameterised-width valid/ready output register with side flag. It is instantiated twice.

Test Plan:
- Encode 0x41, 0xE9, 0x20AC back-to-back with e_uready=1 -> units 0x0041, 0x00E9, 0x20AC on consecutive cycles, e_err=0.
- Encode 0x1F600 -> 0xD83D then 0xDE00. e_ready=0 in the cycle after accept. With e_uready=0 for 3 cycles, 0xD83D holds stable.
- Encode 0x110000 -> e_err=1, unit 0x0000 (0xFFFD with UTF16_REPLACE_EN). Encode 0xDC00 -> e_err=1.
- Decode 0xD83D, 0xDE00 -> d_cp=0x1F600, d_err=0. Decode 0xD83D, 0x0041 -> 0xD83D with d_err=1, then 0x0041. d_ready is low for one cycle.
- Decode 0xD800 then d_flush -> 0xD800 with d_err=1, d_pend falls. Decode 0xDFFF alone -> d_err=1.
- Assert rst_in=0 while encode is in E_LOW and decode in D_HI -> next cycle all valids=0, d_pend=0. 0x0041 then encodes normally.

Source files
------------

// File: rtl/hardware_utf16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hardware_utf16_pkg
// Purpose  : Shared constants, FSM state types and surrogate classifiers for
//            the UTF-16 encode/decode stage.
// Contents : SUR_HI_LO, SUR_LO_LO, SUR_END  - surrogate range boundaries
//            MAX_CP, SUPP_BASE              - code point range limits
//            enc_state_t, dec_state_t       - FSM state encodings
//            is_hi(u), is_lo(u)             - surrogate classification
// Revision : 1.0 - initial release
// ============================================================================
package hardware_utf16_pkg;

    localparam logic [15:0] SUR_HI_LO = 16'hD800;
    localparam logic [15:0] SUR_LO_LO = 16'hDC00;
    localparam logic [15:0] SUR_END   = 16'hDFFF;
    localparam logic [31:0] MAX_CP    = 32'h0010_FFFF;
    localparam logic [31:0] SUPP_BASE = 32'h0001_0000;

    typedef enum logic [0:0] {
        E_IDLE = 1'b0,
        E_LOW  = 1'b1
    } enc_state_t;

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_HI   = 1'b1
    } dec_state_t;

    // High (leading) surrogate: 0xD800..0xDBFF
    function automatic logic is_hi(input logic [15:0] u);
        return (u >= SUR_HI_LO) && (u < SUR_LO_LO);
    endfunction

    // Low (trailing) surrogate: 0xDC00..0xDFFF
    function automatic logic is_lo(input logic [15:0] u);
        return (u >= SUR_LO_LO) && (u <= SUR_END);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hardware_utf16_outreg.sv
`default_nettype none
// ============================================================================
// Module   : hardware_utf16_outreg
// Purpose  : Single-entry valid/ready output register carrying a data word and
//            a one-bit side flag. Loads whenever it is empty or being drained
//            in the same cycle; holds data stable while valid and not ready.
// Ports    : clk      - clock
//            i_rst_n  - synchronous active-low reset
//            i_load   - producer presents a new word (taken only when free)
//            i_data   - word to load
//            i_flag   - side flag stored alongside the word
//            i_ready  - consumer takes the current word
//            o_valid  - word held
//            o_data   - held word
//            o_flag   - held side flag
//            o_free   - register can accept a word this cycle
// Revision : 1.0 - initial release
// ============================================================================
module hardware_utf16_outreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_flag,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_flag,
    output logic             o_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_flag;
    logic             w_free;

    assign w_free  = !r_valid || i_ready;
    assign o_free  = w_free;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_flag  = r_flag;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flag  <= 1'b0;
        end else if (i_load && w_free) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_flag  <= i_flag;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hardware_utf16.sv
`default_nettype none
// ============================================================================
// Module   : hardware_utf16
// Purpose  : UTF-16 stage on the character side of the UTF-8 codec.
//            Encode path: 32-bit code points -> UTF-16 units (surrogate pairs
//            for supplementary characters). Decode path: UTF-16 units ->
//            32-bit code points, pairing surrogates. Paths are independent.
// Config   : UTF16_REPLACE_EN - when defined, flagged outputs carry REPL_CHAR
//            instead of the raw value (err flag still asserted).
// Ports    : clk, rst_in (sync, active-low)
//            e_cp/e_valid/e_ready          - encode input
//            e_unit/e_uvalid/e_uready/e_err - encode output
//            d_unit/d_valid/d_ready/d_flush - decode input
//            d_cp/d_cvalid/d_cready/d_err   - decode output
//            d_pend                         - high surrogate held
// Revision : 1.0 - initial release
// ============================================================================
module hardware_utf16 #(
    parameter logic [15:0] REPL_CHAR = 16'hFFFD
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [31:0] e_cp,
    input  logic        e_valid,
    output logic        e_ready,
    output logic [15:0] e_unit,
    output logic        e_uvalid,
    input  logic        e_uready,
    output logic        e_err,
    input  logic [15:0] d_unit,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_flush,
    output logic [31:0] d_cp,
    output logic        d_cvalid,
    input  logic        d_cready,
    output logic        d_err,
    output logic        d_pend
);

    import hardware_utf16_pkg::*;

`ifdef UTF16_REPLACE_EN
    localparam logic c_replace_en = 1'b1;
`else
    localparam logic c_replace_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Encode path
    // ------------------------------------------------------------------
    enc_state_t  r_e_state;
    logic [15:0] r_e_low;
    logic        w_e_free;
    logic        w_e_accept;
    logic        w_e_load;
    logic        w_e_big;
    logic        w_e_supp;
    logic        w_e_sur;
    logic [19:0] w_e_v;
    logic [15:0] w_e_unit_raw;
    logic        w_e_err_raw;
    logic [15:0] w_e_unit;

    assign e_ready    = (r_e_state == E_IDLE) && w_e_free;
    assign w_e_accept = e_valid && e_ready;
    assign w_e_big    = e_cp > MAX_CP;
    assign w_e_supp   = !w_e_big && (e_cp >= SUPP_BASE);
    assign w_e_sur    = (e_cp < SUPP_BASE) && (is_hi(e_cp[15:0]) || is_lo(e_cp[15:0]));
    // cp - 0x10000 fits in 20 bits for supplementary code points, so the
    // subtraction only needs the low 20 bits of the input.
    assign w_e_v      = e_cp[19:0] - SUPP_BASE[19:0];

    always_comb begin
        w_e_unit_raw = e_cp[15:0];
        w_e_err_raw  = w_e_big || w_e_sur;
        if (r_e_state == E_LOW) begin
            w_e_unit_raw = r_e_low;
            w_e_err_raw  = 1'b0;
        end else if (w_e_supp) begin
            w_e_unit_raw = SUR_HI_LO | {6'b0, w_e_v[19:10]};
        end
    end

    assign w_e_load = w_e_accept || ((r_e_state == E_LOW) && w_e_free);
    assign w_e_unit = (c_replace_en && w_e_err_raw) ? REPL_CHAR : w_e_unit_raw;

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_e_state <= E_IDLE;
            r_e_low   <= '0;
        end else begin
            case (r_e_state)
                E_IDLE: begin
                    if (w_e_accept && w_e_supp) begin
                        r_e_low   <= SUR_LO_LO | {6'b0, w_e_v[9:0]};
                        r_e_state <= E_LOW;
                    end
                end
                E_LOW: begin
                    if (w_e_free) begin
                        r_e_state <= E_IDLE;
                    end
                end
            endcase
        end
    end

    hardware_utf16_outreg #(
        .WIDTH (16)
    ) u_enc_out (
        .clk     (clk),
        .i_rst_n (rst_in),
        .i_load  (w_e_load),
        .i_data  (w_e_unit),
        .i_flag  (w_e_err_raw),
        .i_ready (e_uready),
        .o_valid (e_uvalid),
        .o_data  (e_unit),
        .o_flag  (e_err),
        .o_free  (w_e_free)
    );

    // ------------------------------------------------------------------
    // Decode path
    // ------------------------------------------------------------------
    dec_state_t  r_d_state;
    logic [15:0] r_d_hi;
    logic        w_d_free;
    logic        w_d_unit_lo;
    logic        w_d_accept;
    logic        w_d_flush_hi;
    logic        w_d_load;
    logic        w_d_err_raw;
    logic [31:0] w_d_cp_raw;
    logic [31:0] w_d_cp;

    assign w_d_unit_lo = is_lo(d_unit);
    // With a high held, only a low surrogate can be consumed; anything else
    // is left on the input and re-evaluated once the high has been released.
    assign d_ready     = w_d_free && !((r_d_state == D_HI) && !w_d_unit_lo);
    assign w_d_accept  = d_valid && d_ready;
    // Release the held high as an error: either the next unit cannot complete
    // the pair, or the stream ended. A valid unit outranks d_flush.
    assign w_d_flush_hi = (r_d_state == D_HI) && w_d_free &&
                          (d_valid ? !w_d_unit_lo : d_flush);

    always_comb begin
        w_d_load    = 1'b0;
        w_d_cp_raw  = {16'h0, d_unit};
        w_d_err_raw = 1'b0;
        if (r_d_state == D_IDLE) begin
            w_d_load    = w_d_accept && !is_hi(d_unit);
            w_d_err_raw = w_d_unit_lo;
        end else if (w_d_accept) begin
            w_d_load   = 1'b1;
            w_d_cp_raw = SUPP_BASE + {12'h0, r_d_hi[9:0], d_unit[9:0]};
        end else if (w_d_flush_hi) begin
            w_d_load    = 1'b1;
            w_d_cp_raw  = {16'h0, r_d_hi};
            w_d_err_raw = 1'b1;
        end
    end

    assign w_d_cp = (c_replace_en && w_d_err_raw) ? {16'h0, REPL_CHAR} : w_d_cp_raw;
    assign d_pend = (r_d_state == D_HI);

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_d_state <= D_IDLE;
            r_d_hi    <= '0;
        end else begin
            case (r_d_state)
                D_IDLE: begin
                    if (w_d_accept && is_hi(d_unit)) begin
                        r_d_hi    <= d_unit;
                        r_d_state <= D_HI;
                    end
                end
                D_HI: begin
                    if (w_d_accept || w_d_flush_hi) begin
                        r_d_state <= D_IDLE;
                    end
                end
            endcase
        end
    end

    hardware_utf16_outreg #(
        .WIDTH (32)
    ) u_dec_out (
        .clk     (clk),
        .i_rst_n (rst_in),
        .i_load  (w_d_load),
        .i_data  (w_d_cp),
        .i_flag  (w_d_err_raw),
        .i_ready (d_cready),
        .o_valid (d_cvalid),
        .o_data  (d_cp),
        .o_flag  (d_err),
        .o_free  (w_d_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_hardware_utf16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hardware_utf16
// Purpose  : Self-checking bench for hardware_utf16. Expected units/code
//            points are queued when stimulus is driven and compared when the
//            DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hardware_utf16;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [31:0] e_cp;
    logic        e_valid;
    logic        e_ready;
    logic [15:0] e_unit;
    logic        e_uvalid;
    logic        e_uready;
    logic        e_err;
    logic [15:0] d_unit;
    logic        d_valid;
    logic        d_ready;
    logic        d_flush;
    logic [31:0] d_cp;
    logic        d_cvalid;
    logic        d_cready;
    logic        d_err;
    logic        d_pend;

    always #5 clk = ~clk;

    hardware_utf16 dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .e_cp     (e_cp),
        .e_valid  (e_valid),
        .e_ready  (e_ready),
        .e_unit   (e_unit),
        .e_uvalid (e_uvalid),
        .e_uready (e_uready),
        .e_err    (e_err),
        .d_unit   (d_unit),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_flush  (d_flush),
        .d_cp     (d_cp),
        .d_cvalid (d_cvalid),
        .d_cready (d_cready),
        .d_err    (d_err),
        .d_pend   (d_pend)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] enc_q[$];   // {err, unit}
    logic [32:0] dec_q[$];   // {err, cp}

`ifdef UTF16_REPLACE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    function automatic logic [16:0] enc_exp(input logic err, input logic [15:0] u);
        return {err, (REPL && err) ? 16'hFFFD : u};
    endfunction

    function automatic logic [32:0] dec_exp(input logic err, input logic [31:0] cp);
        return {err, (REPL && err) ? 32'h0000_FFFD : cp};
    endfunction

    // Drivers: called just after a posedge; return just after the accepting posedge.
    task automatic enc_send(input logic [31:0] cp);
        int t = 0;
        e_cp    = cp;
        e_valid = 1'b1;
        @(negedge clk);
        while (!e_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!e_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL enc_send_timeout: e_ready=%0b required 1 (cp=%h)", e_ready, cp);
        end
        @(posedge clk); #1;
    endtask

    task automatic dec_send(input logic [15:0] u);
        int t = 0;
        d_unit  = u;
        d_valid = 1'b1;
        @(negedge clk);
        while (!d_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!d_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL dec_send_timeout: d_ready=%0b required 1 (unit=%h)", d_ready, u);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        e_cp = '0; e_valid = 1'b0; e_uready = 1'b0;
        d_unit = '0; d_valid = 1'b0; d_flush = 1'b0; d_cready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({e_uvalid, e_unit, e_err} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_enc: uvalid=%0b unit=%h err=%0b required all 0", e_uvalid, e_unit, e_err);
        end
        n_cmp++;
        if ({d_cvalid, d_cp, d_err, d_pend} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_dec: cvalid=%0b cp=%h err=%0b pend=%0b required all 0", d_cvalid, d_cp, d_err, d_pend);
        end
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encode_bmp();
        int first_t = -1;
        int last_t  = -1;
        e_uready = 1'b1;
        enc_q.push_back(enc_exp(1'b0, 16'h0041));
        enc_q.push_back(enc_exp(1'b0, 16'h00E9));
        enc_q.push_back(enc_exp(1'b0, 16'h20AC));
        fork
            begin
                enc_send(32'h41);
                enc_send(32'hE9);
                enc_send(32'h20AC);
                e_valid = 1'b0;
            end
            begin
                int t = 0;
                logic [16:0] ex;
                while (enc_q.size() > 0 && t < 100) begin
                    @(negedge clk);
                    t++;
                    if (e_uvalid && e_uready) begin
                        ex = enc_q.pop_front();
                        if (first_t < 0) first_t = t;
                        last_t = t;
                        n_cmp++;
                        if ({e_err, e_unit} !== ex) begin
                            n_bad++;
                            $display("FAIL enc_bmp: got err=%0b unit=%h required err=%0b unit=%h", e_err, e_unit, ex[16], ex[15:0]);
                        end
                    end
                end
                if (enc_q.size() != 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL enc_bmp_timeout: %0d units outstanding, required 0", enc_q.size());
                    enc_q.delete();
                end
            end
        join
        n_cmp++;
        if (last_t - first_t != 2) begin
            n_bad++;
            $display("FAIL enc_bmp_spacing: span=%0d cycles required 2", last_t - first_t);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_encode_supp();
        int t = 0;
        logic [16:0] ex;
        e_uready = 1'b0;
        enc_q.push_back(enc_exp(1'b0, 16'hD83D));
        enc_q.push_back(enc_exp(1'b0, 16'hDE00));
        enc_send(32'h1F600);
        e_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++;
                if (e_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL enc_supp_ready: e_ready=%0b required 0", e_ready);
                end
            end
            n_cmp++;
            if ({e_uvalid, e_unit} !== {1'b1, 16'hD83D}) begin
                n_bad++;
                $display("FAIL enc_supp_hold: uvalid=%0b unit=%h required 1 d83d (cycle %0d)", e_uvalid, e_unit, k);
            end
        end
        @(posedge clk); #1;
        e_uready = 1'b1;
        while (enc_q.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
            if (e_uvalid && e_uready) begin
                ex = enc_q.pop_front();
                n_cmp++;
                if ({e_err, e_unit} !== ex) begin
                    n_bad++;
                    $display("FAIL enc_supp: got err=%0b unit=%h required err=%0b unit=%h", e_err, e_unit, ex[16], ex[15:0]);
                end
            end
        end
        if (enc_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL enc_supp_timeout: %0d units outstanding, required 0", enc_q.size());
            enc_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_encode_errors();
        logic [31:0] cps[8] = '{32'h0011_0000, 32'h0000_DC00, 32'h0000_D7FF, 32'h0000_E000,
                                32'h0000_FFFF, 32'h0010_FFFF, 32'h0000_D800, 32'hFFFF_FFFF};
        e_uready = 1'b1;
        enc_q.push_back(enc_exp(1'b1, 16'h0000));
        enc_q.push_back(enc_exp(1'b1, 16'hDC00));
        enc_q.push_back(enc_exp(1'b0, 16'hD7FF));
        enc_q.push_back(enc_exp(1'b0, 16'hE000));
        enc_q.push_back(enc_exp(1'b0, 16'hFFFF));
        enc_q.push_back(enc_exp(1'b0, 16'hDBFF));
        enc_q.push_back(enc_exp(1'b0, 16'hDFFF));
        enc_q.push_back(enc_exp(1'b1, 16'hD800));
        enc_q.push_back(enc_exp(1'b1, 16'hFFFF));
        fork
            begin
                for (int i = 0; i < 8; i++) enc_send(cps[i]);
                e_valid = 1'b0;
            end
            begin
                int t = 0;
                logic [16:0] ex;
                while (enc_q.size() > 0 && t < 200) begin
                    @(negedge clk);
                    t++;
                    if (e_uvalid && e_uready) begin
                        ex = enc_q.pop_front();
                        n_cmp++;
                        if ({e_err, e_unit} !== ex) begin
                            n_bad++;
                            $display("FAIL enc_err: got err=%0b unit=%h required err=%0b unit=%h", e_err, e_unit, ex[16], ex[15:0]);
                        end
                    end
                end
                if (enc_q.size() != 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL enc_err_timeout: %0d units outstanding, required 0", enc_q.size());
                    enc_q.delete();
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_decode_pairs();
        logic [15:0] us[9] = '{16'hD83D, 16'hDE00, 16'h0041, 16'hFFFF, 16'hE000,
                               16'hDBFF, 16'hDFFF, 16'hD800, 16'hDC00};
        d_cready = 1'b1;
        dec_q.push_back(dec_exp(1'b0, 32'h0001_F600));
        dec_q.push_back(dec_exp(1'b0, 32'h0000_0041));
        dec_q.push_back(dec_exp(1'b0, 32'h0000_FFFF));
        dec_q.push_back(dec_exp(1'b0, 32'h0000_E000));
        dec_q.push_back(dec_exp(1'b0, 32'h0010_FFFF));
        dec_q.push_back(dec_exp(1'b0, 32'h0001_0000));
        fork
            begin
                for (int i = 0; i < 9; i++) dec_send(us[i]);
                d_valid = 1'b0;
            end
            begin
                int t = 0;
                logic [32:0] ex;
                while (dec_q.size() > 0 && t < 200) begin
                    @(negedge clk);
                    t++;
                    if (d_cvalid && d_cready) begin
                        ex = dec_q.pop_front();
                        n_cmp++;
                        if ({d_err, d_cp} !== ex) begin
                            n_bad++;
                            $display("FAIL dec_pair: got err=%0b cp=%h required err=%0b cp=%h", d_err, d_cp, ex[32], ex[31:0]);
                        end
                    end
                end
                if (dec_q.size() != 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dec_pair_timeout: %0d code points outstanding, required 0", dec_q.size());
                    dec_q.delete();
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_decode_lone_high();
        logic [32:0] ex;
        d_cready = 1'b1;
        dec_q.push_back(dec_exp(1'b1, 32'h0000_D83D));
        dec_q.push_back(dec_exp(1'b0, 32'h0000_0041));
        d_unit = 16'hD83D; d_valid = 1'b1;
        @(posedge clk); #1;
        d_unit = 16'h0041;
        @(negedge clk);
        n_cmp++;
        if ({d_pend, d_ready, d_cvalid} !== 3'b100) begin
            n_bad++;
            $display("FAIL dec_lone_stall: pend=%0b ready=%0b cvalid=%0b required 1 0 0", d_pend, d_ready, d_cvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        ex = dec_q.pop_front();
        n_cmp++;
        if ({d_cvalid, d_err, d_cp} !== {1'b1, ex}) begin
            n_bad++;
            $display("FAIL dec_lone_hi: got cvalid=%0b err=%0b cp=%h required 1 %0b %h", d_cvalid, d_err, d_cp, ex[32], ex[31:0]);
        end
        n_cmp++;
        if ({d_pend, d_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL dec_lone_resume: pend=%0b ready=%0b required 0 1", d_pend, d_ready);
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        @(negedge clk);
        ex = dec_q.pop_front();
        n_cmp++;
        if ({d_cvalid, d_err, d_cp} !== {1'b1, ex}) begin
            n_bad++;
            $display("FAIL dec_lone_next: got cvalid=%0b err=%0b cp=%h required 1 %0b %h", d_cvalid, d_err, d_cp, ex[32], ex[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_decode_flush();
        logic [32:0] ex;
        d_cready = 1'b1;
        dec_q.push_back(dec_exp(1'b1, 32'h0000_D800));
        dec_q.push_back(dec_exp(1'b1, 32'h0000_DFFF));
        dec_q.push_back(dec_exp(1'b0, 32'h0001_F600));
        dec_send(16'hD800);
        d_valid = 1'b0; d_flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({d_pend, d_cvalid} !== 2'b10) begin
            n_bad++;
            $display("FAIL dec_flush_pend: pend=%0b cvalid=%0b required 1 0", d_pend, d_cvalid);
        end
        @(posedge clk); #1;
        d_flush = 1'b0;
        @(negedge clk);
        ex = dec_q.pop_front();
        n_cmp++;
        if ({d_cvalid, d_err, d_cp, d_pend} !== {1'b1, ex, 1'b0}) begin
            n_bad++;
            $display("FAIL dec_flush_out: got cvalid=%0b err=%0b cp=%h pend=%0b required 1 %0b %h 0", d_cvalid, d_err, d_cp, d_pend, ex[32], ex[31:0]);
        end
        @(posedge clk); #1;
        d_flush = 1'b1;                 // flush while idle must do nothing
        @(posedge clk); #1;
        d_flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d_cvalid, d_pend} !== 2'b00) begin
            n_bad++;
            $display("FAIL dec_flush_idle: cvalid=%0b pend=%0b required 0 0", d_cvalid, d_pend);
        end
        @(posedge clk); #1;
        dec_send(16'hDFFF);
        d_valid = 1'b0;
        @(negedge clk);
        ex = dec_q.pop_front();
        n_cmp++;
        if ({d_cvalid, d_err, d_cp} !== {1'b1, ex}) begin
            n_bad++;
            $display("FAIL dec_lone_lo: got cvalid=%0b err=%0b cp=%h required 1 %0b %h", d_cvalid, d_err, d_cp, ex[32], ex[31:0]);
        end
        @(posedge clk); #1;
        dec_send(16'hD83D);
        d_flush = 1'b1;                 // valid low unit must win over flush
        dec_send(16'hDE00);
        d_valid = 1'b0; d_flush = 1'b0;
        @(negedge clk);
        ex = dec_q.pop_front();
        n_cmp++;
        if ({d_cvalid, d_err, d_cp} !== {1'b1, ex}) begin
            n_bad++;
            $display("FAIL dec_flush_prio: got cvalid=%0b err=%0b cp=%h required 1 %0b %h", d_cvalid, d_err, d_cp, ex[32], ex[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        e_uready = 1'b0;
        d_cready = 1'b0;
        enc_send(32'h1F600);
        e_valid = 1'b0;
        dec_send(16'hD83D);
        d_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({e_uvalid, d_pend} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_mid_setup: e_uvalid=%0b d_pend=%0b required 1 1", e_uvalid, d_pend);
        end
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({e_uvalid, d_cvalid, d_pend} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_mid_clear: e_uvalid=%0b d_cvalid=%0b d_pend=%0b required 0 0 0", e_uvalid, d_cvalid, d_pend);
        end
        @(posedge clk); #1;
        e_uready = 1'b1;
        d_cready = 1'b1;
        enc_q.push_back(enc_exp(1'b0, 16'h0041));
        fork
            begin
                enc_send(32'h41);
                e_valid = 1'b0;
            end
            begin
                int t = 0;
                logic [16:0] ex;
                while (enc_q.size() > 0 && t < 50) begin
                    @(negedge clk);
                    t++;
                    if (e_uvalid && e_uready) begin
                        ex = enc_q.pop_front();
                        n_cmp++;
                        if ({e_err, e_unit} !== ex) begin
                            n_bad++;
                            $display("FAIL rst_mid_enc: got err=%0b unit=%h required err=%0b unit=%h", e_err, e_unit, ex[16], ex[15:0]);
                        end
                    end
                end
                if (enc_q.size() != 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rst_mid_timeout: %0d units outstanding, required 0", enc_q.size());
                    enc_q.delete();
                end
            end
        join
        @(negedge clk);
        n_cmp++;
        if (e_uvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_stale: e_uvalid=%0b unit=%h required 0", e_uvalid, e_unit);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_encode_bmp();
        test_encode_supp();
        test_encode_errors();
        test_decode_pairs();
        test_decode_lone_high();
        test_decode_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
